// File: rtl/sm_pkg.sv
// Shared types for the bit-serial sign-magnitude adder/subtractor.
// Holds FSM state and operation enums plus the counter-width helper.
package sm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        SHIFT
    } state_t;

    typedef enum logic {
        OP_ADD,
        OP_SUB
    } op_t;

    // Bit counter width for an m-bit magnitude walk.
    function automatic int cnt_width(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sm_serial_bit.sv
// One-bit full adder/subtractor with a registered carry/borrow.
// Ports: clk, rst, clr (zero carry), en (advance carry), op, a, b -> s, cout.
module sm_serial_bit
    import sm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  op_t  op,
    input  logic a,
    input  logic b,
    output logic s,
    output logic cout
);

    logic carry;

    always_comb begin
        s    = a ^ b ^ carry;
        cout = 1'b0;
        unique case (op)
            OP_ADD: cout = (a & b) | (carry & (a ^ b));
            OP_SUB: cout = (~a & b) | (~(a ^ b) & carry);
            default: cout = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= cout;
        end
    end

endmodule

// File: rtl/sm_addsub_serial.sv
// Bit-serial sign-magnitude add/sub with start/done handshake.
// Ports: clk, rst, start, num1, num2, selection -> busy, done, result, zeroflag.
module sm_addsub_serial
    import sm_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] num2,
    input  logic         selection,
    output logic         busy,
    output logic         done,
    output logic [W:0]   result,
    output logic         zeroflag
);

    localparam int M  = W - 1;
    localparam int CW = cnt_width(M);

    state_t         state;
    op_t            op_q;
    logic [W-1:0]   a_cap;
    logic [W-1:0]   b_cap;
    logic           sel_cap;
    logic [M-1:0]   a_sr;
    logic [M-1:0]   b_sr;
    logic [M-1:0]   r_sr;
    logic           sign_q;
    logic [CW-1:0]  cnt;

    logic [M-1:0]   ma;
    logic [M-1:0]   mb;
    logic           sa;
    logic           sb;
    logic           swap;
    logic           big_sign;
    op_t            prep_op;
    logic           prep_sign;

    logic           s_bit;
    logic           c_bit;
    logic [M-1:0]   r_nxt;
    logic [M:0]     mag_nxt;
    logic           last;

    // Operand conditioning: larger magnitude always goes to the A
    // register so subtraction never ends with an outstanding borrow.
    always_comb begin
        ma        = a_cap[M-1:0];
        mb        = b_cap[M-1:0];
        sa        = a_cap[W-1];
        sb        = b_cap[W-1] ^ sel_cap;
        swap      = (mb > ma);
        big_sign  = swap ? sb : sa;
        prep_op   = (sa == sb) ? OP_ADD : OP_SUB;
        prep_sign = (prep_op == OP_ADD) ? sa : big_sign;
    end

    sm_serial_bit u_bit (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == PREP),
        .en   (state == SHIFT),
        .op   (op_q),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .s    (s_bit),
        .cout (c_bit)
    );

    // Result bits enter at the top and walk down, so after M shifts
    // bit 0 of the magnitude sits at r_sr[0].
    always_comb begin
        r_nxt   = (r_sr >> 1) | (M'(s_bit) << (M - 1));
        mag_nxt = {(op_q == OP_ADD) ? c_bit : 1'b0, r_nxt};
        last    = (cnt == CW'(M - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            a_cap    <= '0;
            b_cap    <= '0;
            sel_cap  <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            sign_q   <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zeroflag <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_cap   <= num1;
                        b_cap   <= num2;
                        sel_cap <= selection;
                        busy    <= 1'b1;
                        state   <= PREP;
                    end
                end
                PREP: begin
                    a_sr   <= swap ? mb : ma;
                    b_sr   <= swap ? ma : mb;
                    op_q   <= prep_op;
                    sign_q <= prep_sign;
                    r_sr   <= '0;
                    cnt    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        // No negative zero on the output.
                        result   <= {(mag_nxt == '0) ? 1'b0 : sign_q,
                                     mag_nxt};
                        zeroflag <= (mag_nxt == '0);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
